// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM with bounded mem_ready wait
module multicycle_ctrl #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       InstrDone,
    output logic       IllegalOp,
    output logic       BusErr,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_ALUWB, S_EXECI, S_JAL, S_BRANCH, S_JALR, S_JALRWB, S_LUI, S_AUIPC
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [15:0] WAIT_LAST = 16'(WAIT_MAX - 1);

    state_t      state_q, state_d;
    logic [15:0] wait_q, wait_d;
    logic        waiting, timeout;
    logic        pcw_c, mw_c, irw_c, rw_c, done_c, ill_c, be_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            wait_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // The count before this cycle equals WAIT_LAST means this cycle is the WAIT_MAX-th idle one.
    assign waiting = ((state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE))
                     && !mem_ready;
    assign timeout = waiting && (wait_q == WAIT_LAST);

    always_comb begin
        wait_d = 16'd0;
        if (waiting && !timeout && (state_d == state_q) && (wait_q != 16'hFFFF))
            wait_d = wait_q + 16'd1;
    end

    always_comb begin
        state_d   = state_q;
        pcw_c     = 1'b0;
        mw_c      = 1'b0;
        irw_c     = 1'b0;
        rw_c      = 1'b0;
        done_c    = 1'b0;
        ill_c     = 1'b0;
        be_c      = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    irw_c   = 1'b1;
                    pcw_c   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    be_c = 1'b1;
                end
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXECR;
                    OP_IMM:            state_d = S_EXECI;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default: begin
                        state_d = S_FETCH;
                        ill_c   = 1'b1;
                        done_c  = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end else if (timeout) begin
                    be_c    = 1'b1;
                    done_c  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                rw_c      = 1'b1;
                done_c    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mw_c   = 1'b1;
                if (mem_ready) begin
                    done_c  = 1'b1;
                    state_d = S_FETCH;
                end else if (timeout) begin
                    be_c    = 1'b1;
                    done_c  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                rw_c    = 1'b1;
                done_c  = 1'b1;
                state_d = S_FETCH;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                pcw_c   = 1'b1;
                state_d = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                done_c  = 1'b1;
                pcw_c   = ((funct3 == 3'b000) && Zero) || ((funct3 == 3'b001) && !Zero);
                state_d = S_FETCH;
            end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pcw_c     = 1'b1;
                state_d   = S_JALRWB;
            end
            S_JALRWB: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                rw_c      = 1'b1;
                done_c    = 1'b1;
                state_d   = S_FETCH;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            S_AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_STORE:          ImmSrc = 3'b001;
            OP_BRANCH:         ImmSrc = 3'b010;
            OP_JAL:            ImmSrc = 3'b011;
            OP_LUI, OP_AUIPC:  ImmSrc = 3'b100;
            default:           ImmSrc = 3'b000;
        endcase
    end

    // Strobes are masked during reset since FETCH would otherwise follow mem_ready.
    assign PCWrite   = pcw_c  & ~rst;
    assign MemWrite  = mw_c   & ~rst;
    assign IRWrite   = irw_c  & ~rst;
    assign RegWrite  = rw_c   & ~rst;
    assign InstrDone = done_c & ~rst;
    assign IllegalOp = ill_c  & ~rst;
    assign BusErr    = be_c   & ~rst;
    assign State     = state_q;
endmodule
